// File: rtl/seq_serializer.sv
// Parallel-in, serial-out converter with a valid/ready input handshake and a
// one-entry holding buffer, so back-to-back words leave without a gap.
module seq_serializer #(
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          dout,
    output logic          dout_vld,
    output logic          busy
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] LAST_IDX = CW'(DW - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_sh_reg;
    logic [CW-1:0] r_bit_cnt;
    logic [DW-1:0] r_hold_reg;
    logic          r_hold_full;

    state_t        w_state_nx;
    logic [DW-1:0] w_sh_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [DW-1:0] w_hold_nx;
    logic          w_hold_full_nx;

    logic          w_sh_act;
    logic          w_accept;
    logic          w_last;
    logic [DW-1:0] w_shifted;

    assign w_sh_act  = (r_state == S_SHIFT);
    assign w_accept  = in_valid & ~r_hold_full;
    assign w_last    = w_sh_act & (r_bit_cnt == LAST_IDX);
    // Shift toward whichever end feeds dout, filling with zero.
    assign w_shifted = MSB_FIRST ? {r_sh_reg[DW-2:0], 1'b0} : {1'b0, r_sh_reg[DW-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh_reg    <= '0;
            r_bit_cnt   <= '0;
            r_hold_reg  <= '0;
            r_hold_full <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            r_state     <= w_state_nx;
            r_sh_reg    <= w_sh_nx;
            r_bit_cnt   <= w_cnt_nx;
            r_hold_reg  <= w_hold_nx;
            r_hold_full <= w_hold_full_nx;
        end
    end

    always_comb begin
        // NOTE: default every next-state value to its current value so no latch is inferred.
        w_state_nx     = r_state;
        w_sh_nx        = r_sh_reg;
        w_cnt_nx       = r_bit_cnt;
        w_hold_nx      = r_hold_reg;
        w_hold_full_nx = r_hold_full;

        if (clr) begin
            w_state_nx     = S_IDLE;
            w_cnt_nx       = '0;
            w_hold_full_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_sh_nx    = in_data;
                        w_cnt_nx   = '0;
                        w_state_nx = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        w_cnt_nx = '0;
                        if (r_hold_full) begin
                            w_sh_nx        = r_hold_reg;
                            w_hold_full_nx = 1'b0;
                        end else if (w_accept) begin
                            w_sh_nx = in_data;
                        end else begin
                            w_sh_nx    = w_shifted;
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_sh_nx  = w_shifted;
                        w_cnt_nx = r_bit_cnt + CW'(1);
                        if (w_accept) begin
                            w_hold_nx      = in_data;
                            w_hold_full_nx = 1'b1;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = ~r_hold_full;
        dout_vld = w_sh_act;
        dout     = w_sh_act & (MSB_FIRST ? r_sh_reg[DW-1] : r_sh_reg[0]);
        busy     = w_sh_act | r_hold_full;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-in, serial-out converter that produces the bit stream (din) consumed by the sequence detectors in typical_circuit/seq_check.
- Accepts DW-bit words over a valid/ready handshake and shifts them out one bit per clk, with a qualifying valid flag.
- A one-entry holding buffer lets back-to-back words stream with no idle cycle between words. A synchronous clear drops all buffered data.

Parameters:
- DW, 8, word width in bits; legal range DW >= 2.
- MSB_FIRST, 1, 1 = bit DW-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear; discards shifter and holding buffer contents.
- in_data  input  DW  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; 0 when dout_vld=0.
- dout_vld  output  1  dout carries a valid bit this cycle.
- busy  output  1  shifter active or holding buffer full.

Behaviour:
- State: shifter sh_reg[DW-1:0], bit counter bit_cnt (clog2(DW) bits), sh_act flag, holding register hold_reg[DW-1:0], hold_full flag.
- Reset (rst_n=0, async): sh_reg=0, bit_cnt=0, sh_act=0, hold_reg=0, hold_full=0.
- Outputs after reset: dout=0, dout_vld=0, in_ready=1, busy=0.
- Combinational outputs, decoded from flops only:
  - in_ready = !hold_full. It does not depend on in_valid.
  - dout_vld = sh_act.
  - dout = sh_act & (MSB_FIRST ? sh_reg[DW-1] : sh_reg[0]).
  - busy = sh_act | hold_full.
- accept = in_valid & in_ready, sampled at the rising edge.
- Shift: while sh_act=1, each edge shifts sh_reg one position toward the output end (fill 0) and increments bit_cnt.
- last = sh_act & (bit_cnt == DW-1).
- Next-state rules at each edge, priority top-down:
  1. clr=1: sh_act=0, hold_full=0, bit_cnt=0. Any accept in this cycle is dropped. in_ready still reads 1 the cycle after clr.
  2. sh_act=0 and accept: load in_data into sh_reg, bit_cnt=0, sh_act=1. First bit is on dout in the cycle after the accepting edge, i.e. 1-cycle latency.
  3. last and hold_full: load hold_reg into sh_reg, bit_cnt=0, hold_full=0. No accept can occur because in_ready=0.
  4. last and !hold_full and accept: load in_data directly into sh_reg, bit_cnt=0, sh_act stays 1.
  5. last and no word available: sh_act=0, bit_cnt=0.
  6. sh_act=1, not last, accept: hold_reg=in_data, hold_full=1, shifting continues.
- Throughput: with in_valid held high, dout_vld stays high continuously. Words are emitted in acceptance order with no gap, duplicate or drop.
- in_ready deasserts for the cycles hold_full=1. A word presented with in_ready=0 must be held by the source and is not consumed.
- Reset mid-word: all state is lost immediately; the partial word is not resumed.
- Downstream detector state is not touched by this block.

Test Plan:
- Single word: DW=8, MSB_FIRST=1, in_data=8'hB0 for one accepted cycle -> dout_vld high for exactly 8 cycles starting 1 cycle after the accept; dout = 1,0,1,1,0,0,0,0; then dout_vld=0, busy=0.
- Back-to-back: in_valid high with 8'hB0, 8'h5A, 8'hFF presented on successive handshakes -> 24 consecutive dout_vld cycles with bits in order. in_ready=0 while the buffer is full: from the 2nd accept until the edge that loads word 2 into the shifter, and likewise for word 3. No bubbles.
- Backpressure hold: hold_full=1 with in_valid high and in_data=8'h33 held -> not consumed until in_ready=1; then accepted exactly once and output exactly once.
- clr mid-word: clr pulsed after 3 bits of 8'hB0 with a word in hold -> next cycle dout_vld=0, busy=0, in_ready=1. A subsequent word 8'h0F is emitted cleanly as 0,0,0,0,1,1,1,1.
- Async reset mid-stream: rst_n low between edges during a shift -> dout=0, dout_vld=0, in_ready=1 immediately, without waiting for a clock edge. After release, a new word is emitted from bit 0 of the sequence.
- LSB-first: MSB_FIRST=0, in_data=8'h0D -> dout = 1,0,1,1,0,0,0,0. Feeding this into the 10110 detector produces one detection.
